// File: rtl/ucsbece154b_refill_assembler.sv
// Cache-line refill assembler: pops BLOCK_WORDS words from the memory-response FIFO,
// forwards the requested word early, then hands the packed line to the cache.
module ucsbece154b_refill_assembler #(
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              req_valid_i,
    input  logic [ADDR_WIDTH-1:0]             req_addr_i,
    output logic                              req_ready_o,
    input  logic [DATA_WIDTH-1:0]             fifo_data_i,
    input  logic                              fifo_valid_i,
    output logic                              fifo_pop_o,
    output logic                              crit_valid_o,
    output logic [DATA_WIDTH-1:0]             crit_data_o,
    output logic                              line_valid_o,
    input  logic                              line_ready_i,
    output logic [ADDR_WIDTH-1:0]             line_addr_o,
    output logic [BLOCK_WORDS*DATA_WIDTH-1:0] line_data_o
);

    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << (OFF_W + 2)) - 64'd1);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                              state_q, state_d;
    logic [OFF_W-1:0]                    count_q, count_d;
    logic [OFF_W-1:0]                    offset_q, offset_d;
    logic [ADDR_WIDTH-1:0]               line_addr_q, line_addr_d;
    logic [BLOCK_WORDS*DATA_WIDTH-1:0]   line_data_q, line_data_d;
    logic                                line_valid_q, line_valid_d;
    logic                                crit_valid_q, crit_valid_d;
    logic [DATA_WIDTH-1:0]               crit_data_q, crit_data_d;
    logic                                pop;

    // Words only leave the FIFO while filling; DONE ignores a valid head word.
    assign pop = (state_q == FILL) && fifo_valid_i;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        offset_d     = offset_q;
        line_addr_d  = line_addr_q;
        line_data_d  = line_data_q;
        line_valid_d = line_valid_q;
        crit_valid_d = 1'b0;
        crit_data_d  = crit_data_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    line_addr_d = req_addr_i & ~OFF_MASK;
                    offset_d    = req_addr_i[OFF_W+1:2];
                    count_d     = '0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                if (pop) begin
                    line_data_d[count_q*DATA_WIDTH +: DATA_WIDTH] = fifo_data_i;
                    count_d = count_q + OFF_W'(1);
                    if (count_q == offset_q) begin
                        crit_valid_d = 1'b1;
                        crit_data_d  = fifo_data_i;
                    end
                    if (count_q == LAST_WORD) begin
                        line_valid_d = 1'b1;
                        state_d      = DONE;
                    end
                end
            end
            DONE: begin
                if (line_ready_i) begin
                    line_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            count_q      <= '0;
            offset_q     <= '0;
            line_addr_q  <= '0;
            line_data_q  <= '0;
            line_valid_q <= 1'b0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            offset_q     <= offset_d;
            line_addr_q  <= line_addr_d;
            line_data_q  <= line_data_d;
            line_valid_q <= line_valid_d;
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign fifo_pop_o   = pop;
    assign crit_valid_o = crit_valid_q;
    assign crit_data_o  = crit_data_q;
    assign line_valid_o = line_valid_q;
    assign line_addr_o  = line_addr_q;
    assign line_data_o  = line_data_q;

endmodule
